// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one shared 12-bit uniform_adder processes one slice per
// cycle, LSB first, with the slice carry chained through a carry register.

module uniform_adder (
  input  logic [11:0] inp1,
  input  logic [11:0] inp2,
  input  logic        cin,
  output logic [11:0] out,
  output logic        cout
);

  assign {cout, out} = {1'b0, inp1} + {1'b0, inp2} + {12'd0, cin};

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4,
  parameter int SLICE = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE*WORDS-1:0] a,
  input  logic [SLICE*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE*WORDS-1:0] result,
  output logic                   cout,
  output logic                   busy
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  if (SLICE != 12 || WORDS < 2 || WORDS > 16) begin : gBadParam
    $error("wide_add_sequencer: SLICE must be 12 and WORDS must be in 2..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           carry_q, carry_d;
  logic                           cout_q, cout_d;
  logic [WORDS-1:0][SLICE-1:0]    a_q, a_d;
  logic [WORDS-1:0][SLICE-1:0]    b_q, b_d;
  logic [WORDS-1:0][SLICE-1:0]    res_q, res_d;

  logic [SLICE-1:0] sliceSum;
  logic             sliceCarry;

  uniform_adder uAdder (
    .inp1 (a_q[idx_q]),
    .inp2 (b_q[idx_q]),
    .cin  (carry_q),
    .out  (sliceSum),
    .cout (sliceCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Result is cleared at accept so unwritten slices read 0 while the add is in flight.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = sliceSum;
        carry_d      = sliceCarry;
        if (idx_q == LAST) begin
          cout_d  = sliceCarry;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign cout      = cout_q;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs WORDS×12-bit wide additions (48-bit by default) using one shared 12-bit uniform_adder instance.
- The adder's port order is (inp1, inp2, cin, out, cout), and it is purely combinational.
- Each cycle the block feeds one 12-bit slice to the adder, LSB slice first, and chains the adder's cout into the next slice's cin.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

Parameters:
- WORDS, 4, number of 12-bit slices per operation; operand width is W = 12*WORDS; legal range 2..16.
- SLICE, 12, slice width; fixed at 12 to match uniform_adder. Any other value is illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set available.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into slice 0.
- out_valid  output  1  result and cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum (A + B + cin) mod 2^W.
- cout  output  1  carry out of the top slice.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE, slice index = 0, carry register = 0.
  - Operand registers = 0, result = 0, cout = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- States are IDLE, RUN and DONE. The encoding is implementation choice.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: capture a, b, cin into internal registers; clear result to 0; set idx = 0; go to RUN.
  - Inputs a, b and cin are ignored at all other times. The producer may change them freely after acceptance.
- RUN (one slice per cycle):
  - Adder inputs are inp1 = A[12*idx +: 12], inp2 = B[12*idx +: 12], cin = carry register.
  - At the clock edge: result[12*idx +: 12] <= adder out; carry register <= adder cout.
  - If idx == WORDS-1: cout <= adder cout and go to DONE. Otherwise idx <= idx+1.
  - The adder is used exclusively by this block; no other requester.
- DONE:
  - out_valid = 1; result and cout are held stable.
  - On out_ready high at a clock edge: go to IDLE. out_valid drops and in_ready rises the following cycle.
  - out_ready low holds DONE indefinitely with no change to any output.
- Latency: exactly WORDS cycles from the accepting edge to the edge at which out_valid goes high.
- Throughput: one operation per WORDS+2 cycles at best (accept, WORDS RUN cycles, handshake). Operations never overlap.
- in_valid while not in IDLE has no effect. The producer must hold in_valid until it sees in_ready.
- out_ready while not in DONE has no effect.
- Arithmetic:
  - result is the unsigned sum mod 2^W.
  - cout is bit W of the full sum.
  - A slice carry of 1 out of slice k is added into slice k+1 only; there is no other carry path.
- Wrap-around: an all-ones + 1 input ripples the carry through every slice and yields result 0, cout 1.
- result is undefined-free: it is cleared at accept, so slices not yet written read 0 while busy.

Test Plan:
- Reset: hold rst_n low 3 cycles -> in_ready=1, out_valid=0, busy=0, result=0, cout=0. Assert rst_n asynchronously mid-cycle -> outputs clear immediately, without waiting for a clock edge.
- Basic add: a=48'h000000000003, b=48'h000000000002, cin=0 -> out_valid exactly 4 cycles after the accept edge; result=48'h000000000005, cout=0. Then a=0, b=0, cin=1 -> result=48'h000000000001.
- Slice boundary and top carry:
  - a=48'h000000000FFF, b=48'h000000000001 -> result=48'h000000001000, cout=0.
  - a=48'h800000000000, b=48'h800000000002 -> result=48'h000000000002, cout=1.
- Full ripple: a=48'hFFFFFFFFFFFF, b=48'h000000000001, cin=0 -> result=48'h000000000000, cout=1. Check the carry register is 1 after each RUN cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and different a/b -> result and cout stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE the next cycle, after which new operands are accepted.
- Reset mid-operation: accept a=48'hFFFFFFFFFFFF, b=1; pulse rst_n low after 2 RUN cycles -> out_valid is never asserted for that operation. After release, a=48'h000000000003, b=48'h000000000002 -> result=48'h000000000005 after 4 cycles.
